cmp_arbiter: RTL and testbench

- Shares one signed 32-bit compare unit (the team's `comparator` module, select codes 000–100) between two requesters: port 0 (branch resolution) and port 1 (set-on-compare/trap logic).
- Round-robin arbitration with valid/ready handshakes on both request ports.
- One registered result stage with its own valid/ready handshake, so back-to-back compares run at one per cycle when the consumer is ready.

---
 rtl/cmp_arbiter.sv | 94 +++++++++
 tb/tb_cmp_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// Two-port round-robin arbiter sharing one signed 32-bit compare unit,
// with a single registered response stage under valid/ready flow control.
module cmp_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_result,
  output logic             rsp_err,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic             last_grant;
  logic             grant0, grant1, can_accept;
  logic             xfer0, xfer1;
  logic [31:0]      sel_a, sel_b;
  logic [2:0]       sel_op;
  logic [TAG_W-1:0] sel_tag;
  logic             cmp_res, cmp_err;

  // Returns {err, result}. Differing signs decide by sign alone; otherwise
  // the low 31 bits order the operands as unsigned values.
  function automatic logic [1:0] compare(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [2:0]  op);
    logic eq, lt;
    eq = (a == b);
    lt = (a[31] != b[31]) ? a[31] : (a[30:0] < b[30:0]);
    case (op)
      3'b000:  compare = {1'b0, eq};
      3'b001:  compare = {1'b0, ~lt & ~eq};
      3'b010:  compare = {1'b0, lt};
      3'b011:  compare = {1'b0, ~lt};
      3'b100:  compare = {1'b0, lt | eq};
      default: compare = 2'b10;
    endcase
  endfunction

  always_comb begin
    can_accept = (state == EMPTY) || rsp_ready;
    grant0     = req0_valid & (~req1_valid | last_grant);
    grant1     = req1_valid & (~req0_valid | ~last_grant);
    req0_ready = ~reset & can_accept & grant0;
    req1_ready = ~reset & can_accept & grant1;
    xfer0      = req0_valid & req0_ready;
    xfer1      = req1_valid & req1_ready;
    sel_a      = grant1 ? req1_a   : req0_a;
    sel_b      = grant1 ? req1_b   : req0_b;
    sel_op     = grant1 ? req1_op  : req0_op;
    sel_tag    = grant1 ? req1_tag : req0_tag;
    {cmp_err, cmp_res} = compare(sel_a, sel_b, sel_op);
  end

  assign rsp_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      rsp_result <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
    end else if (xfer0 || xfer1) begin
      state      <= FULL;
      last_grant <= xfer1;
      rsp_result <= cmp_res;
      rsp_err    <= cmp_err;
      rsp_id     <= xfer1;
      rsp_tag    <= sel_tag;
    end else if (state == FULL && rsp_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed table-driven bench for cmp_arbiter: compare ops, signed
// boundaries, round-robin fairness, backpressure and mid-operation reset.
module tb_cmp_arbiter;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_op, req1_op;
  logic [TAG_W-1:0] req0_tag, req1_tag, rsp_tag;
  logic             rsp_valid, rsp_ready, rsp_result, rsp_err, rsp_id;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  cmp_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .rsp_id(rsp_id), .rsp_tag(rsp_tag)
  );

  typedef struct {
    logic             rst;
    logic             v0;
    logic [2:0]       op0;
    logic [31:0]      a0, b0;
    logic [TAG_W-1:0] t0;
    logic             v1;
    logic [2:0]       op1;
    logic [31:0]      a1, b1;
    logic [TAG_W-1:0] t1;
    logic             rr;
    logic             e_r0, e_r1, e_v, e_res, e_err, e_id;
    logic [TAG_W-1:0] e_tag;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check readies before the edge and the
  // response register after it.
  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    reset = v.rst; rsp_ready = v.rr;
    req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0; req0_tag = v.t0;
    req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1; req1_tag = v.t1;
    #1;
    chk({nm, ".req0_ready"}, 32'(req0_ready), 32'(v.e_r0));
    chk({nm, ".req1_ready"}, 32'(req1_ready), 32'(v.e_r1));
    @(posedge clk);
    #1;
    chk({nm, ".rsp_valid"}, 32'(rsp_valid), 32'(v.e_v));
    if (v.e_v || v.rst) begin
      chk({nm, ".rsp_result"}, 32'(rsp_result), 32'(v.e_res));
      chk({nm, ".rsp_err"},    32'(rsp_err),    32'(v.e_err));
      chk({nm, ".rsp_id"},     32'(rsp_id),     32'(v.e_id));
      chk({nm, ".rsp_tag"},    32'(rsp_tag),    32'(v.e_tag));
    end
  endtask

  vec_t tbl[15];
  vec_t hold_v, grab_v, rst_v, both_v;

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_tag = '0;

    //         rst  v0   op0     a0            b0            t0    v1   op1     a1            b1            t1    rr   r0   r1   v    res  err  id   tag
    tbl[0]  = '{1'b1,1'b1,3'b000,32'h5,       32'h5,        4'h3, 1'b0,3'b000,32'h0,        32'h0,        4'h0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0};
    tbl[1]  = '{1'b0,1'b1,3'b000,32'h5,       32'h5,        4'h3, 1'b0,3'b000,32'h0,        32'h0,        4'h0, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,4'h3};
    tbl[2]  = '{1'b0,1'b0,3'b000,32'h0,       32'h0,        4'h0, 1'b1,3'b010,32'h80000000, 32'h7FFFFFFF, 4'h1, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,4'h1};
    tbl[3]  = '{1'b0,1'b0,3'b000,32'h0,       32'h0,        4'h0, 1'b1,3'b001,32'hFFFFFFFF, 32'h00000000, 4'h2, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,4'h2};
    tbl[4]  = '{1'b0,1'b0,3'b000,32'h0,       32'h0,        4'h0, 1'b1,3'b011,32'h12345678, 32'h12345678, 4'h4, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,4'h4};
    tbl[5]  = '{1'b0,1'b0,3'b000,32'h0,       32'h0,        4'h0, 1'b1,3'b100,32'hFFFFFFF9, 32'hFFFFFFF9, 4'h5, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,4'h5};
    tbl[6]  = '{1'b0,1'b0,3'b000,32'h0,       32'h0,        4'h0, 1'b1,3'b110,32'h1,        32'h2,        4'h6, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,4'h6};
    tbl[7]  = '{1'b0,1'b1,3'b001,32'h7FFFFFFF,32'h80000000, 4'h7, 1'b0,3'b000,32'h0,        32'h0,        4'h0, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,4'h7};
    tbl[8]  = '{1'b0,1'b0,3'b000,32'h0,       32'h0,        4'h0, 1'b0,3'b000,32'h0,        32'h0,        4'h0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0};
    // Contention from reset: grants must alternate starting with port 0.
    tbl[9]  = '{1'b1,1'b1,3'b001,32'h3,       32'h2,        4'hA, 1'b1,3'b010,32'h3,        32'h2,        4'hB, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0};
    for (int i = 10; i < 15; i++) tbl[i] = tbl[9];
    tbl[10].rst = 1'b0; tbl[10].e_r0 = 1'b1; tbl[10].e_v = 1'b1; tbl[10].e_res = 1'b1; tbl[10].e_id = 1'b0; tbl[10].e_tag = 4'hA;
    tbl[11] = tbl[10];  tbl[11].e_r0 = 1'b0; tbl[11].e_r1 = 1'b1; tbl[11].e_res = 1'b0; tbl[11].e_id = 1'b1; tbl[11].e_tag = 4'hB;
    tbl[12] = tbl[10];
    tbl[13] = tbl[11];
    tbl[14] = tbl[10];

    for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("vec%0d", i));
    step(tbl[11], "fair6");

    // Backpressure: response for port 1 (tag B) held while both ports wait.
    hold_v = tbl[11];
    hold_v.rr = 1'b0; hold_v.e_r0 = 1'b0; hold_v.e_r1 = 1'b0;
    for (int i = 0; i < 4; i++) step(hold_v, $sformatf("stall%0d", i));
    grab_v = tbl[10];
    step(grab_v, "unstall");

    // Reset while FULL with port 0 pending.
    rst_v = tbl[9];
    rst_v.v1 = 1'b0; rst_v.rr = 1'b0;
    step(rst_v, "midreset");
    both_v = tbl[10];
    step(both_v, "post_rst0");
    step(tbl[11], "post_rst1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
